// File: rtl/mpc_axil_port_router.sv
// AXI-Lite target router: fans one upstream AXI-Lite stream out to PORT_NUM per-port
// register slaves, one transaction outstanding, with local DECERR for unpopulated offsets.
//
// state | meaning
// IDLE  | waiting for an eligible read or write; grant cycle asserts upstream readies
// WREQ  | AW and W presented to the selected port until each handshake completes
// WRSP  | waiting for the selected port's write response
// BOUT  | write response presented upstream until s_bready
// RREQ  | AR presented to the selected port until m_arready
// RRSP  | waiting for the selected port's read data
// ROUT  | read data presented upstream until s_rready
module mpc_axil_port_router #(
   parameter  int PORT_NUM = 4,
   parameter  int PORT_AW  = 10,
   localparam int PW       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [31:0]             s_awaddr,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   input  logic [31:0]             s_wdata,
   input  logic [3:0]              s_wstrb,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   output logic [1:0]              s_bresp,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   input  logic [31:0]             s_araddr,
   input  logic [3:0]              s_aruser,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [31:0]             s_rdata,
   output logic [1:0]              s_rresp,
   output logic [PORT_NUM-1:0]     m_awvalid,
   input  logic [PORT_NUM-1:0]     m_awready,
   output logic [PORT_NUM-1:0]     m_wvalid,
   input  logic [PORT_NUM-1:0]     m_wready,
   output logic [PORT_NUM-1:0]     m_arvalid,
   input  logic [PORT_NUM-1:0]     m_arready,
   output logic [PORT_AW-1:0]      m_awaddr,
   output logic [PORT_AW-1:0]      m_araddr,
   output logic [31:0]             m_wdata,
   output logic [3:0]              m_wstrb,
   output logic [3:0]              m_aruser,
   input  logic [PORT_NUM-1:0]     m_bvalid,
   output logic [PORT_NUM-1:0]     m_bready,
   input  logic [2*PORT_NUM-1:0]   m_bresp,
   input  logic [PORT_NUM-1:0]     m_rvalid,
   output logic [PORT_NUM-1:0]     m_rready,
   input  logic [32*PORT_NUM-1:0]  m_rdata,
   input  logic [2*PORT_NUM-1:0]   m_rresp,
   output logic                    busy
);

   typedef enum logic [2:0] {IDLE, WREQ, WRSP, BOUT, RREQ, RRSP, ROUT} state_t;

   localparam logic [PW:0] PORT_NUM_W = (PW+1)'(PORT_NUM);

   state_t              state_q, state_d;
   logic                last_wr_q, last_wr_d;
   logic                aw_pend_q, aw_pend_d;
   logic                w_pend_q, w_pend_d;
   logic [PORT_AW-1:0]  addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [3:0]          aruser_q, aruser_d;
   logic [PW-1:0]       port_q, port_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [PW-1:0]       awport, arport;
   logic                aw_err, ar_err;
   logic                wr_elig, rd_elig, grant_wr;
   logic [PORT_NUM-1:0] sel;
   logic                aw_hs, w_hs, ar_hs, b_hit, r_hit;

   assign awport  = s_awaddr[PORT_AW +: PW];
   assign arport  = s_araddr[PORT_AW +: PW];
   assign aw_err  = ({1'b0, awport} >= PORT_NUM_W) || (s_awaddr[31:PORT_AW+PW] != '0);
   assign ar_err  = ({1'b0, arport} >= PORT_NUM_W) || (s_araddr[31:PORT_AW+PW] != '0);

   // Write needs both AW and W; on contention the side not granted last time wins.
   assign wr_elig  = s_awvalid && s_wvalid;
   assign rd_elig  = s_arvalid;
   assign grant_wr = wr_elig && (!rd_elig || !last_wr_q);

   assign sel   = PORT_NUM'(1) << port_q;
   assign aw_hs = |(m_awready & sel);
   assign w_hs  = |(m_wready & sel);
   assign ar_hs = |(m_arready & sel);
   assign b_hit = |(m_bvalid & sel);
   assign r_hit = |(m_rvalid & sel);

   assign m_awvalid = aw_pend_q ? sel : '0;
   assign m_wvalid  = w_pend_q ? sel : '0;
   assign m_arvalid = (state_q == RREQ) ? sel : '0;
   assign m_bready  = (state_q == WRSP) ? sel : '0;
   assign m_rready  = (state_q == RRSP) ? sel : '0;
   assign m_awaddr  = addr_q;
   assign m_araddr  = addr_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_aruser  = aruser_q;

   assign s_bvalid = (state_q == BOUT);
   assign s_rvalid = (state_q == ROUT);
   assign s_bresp  = bresp_q;
   assign s_rresp  = rresp_q;
   assign s_rdata  = rdata_q;
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aruser_d  = aruser_q;
      port_d    = port_q;
      bresp_d   = bresp_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_arready = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               s_awready = 1'b1;
               s_wready  = 1'b1;
               last_wr_d = 1'b1;
               addr_d    = s_awaddr[PORT_AW-1:0];
               wdata_d   = s_wdata;
               wstrb_d   = s_wstrb;
               port_d    = awport;
               if (aw_err) begin
                  bresp_d = 2'b11;
                  state_d = BOUT;
               end else begin
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  state_d   = WREQ;
               end
            end else if (rd_elig) begin
               s_arready = 1'b1;
               last_wr_d = 1'b0;
               addr_d    = s_araddr[PORT_AW-1:0];
               aruser_d  = s_aruser;
               port_d    = arport;
               if (ar_err) begin
                  rresp_d = 2'b11;
                  rdata_d = '0;
                  state_d = ROUT;
               end else begin
                  state_d = RREQ;
               end
            end
         end
         WREQ: begin
            if (aw_pend_q && aw_hs) aw_pend_d = 1'b0;
            if (w_pend_q && w_hs)   w_pend_d  = 1'b0;
            if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) state_d = WRSP;
         end
         WRSP: begin
            if (b_hit) begin
               bresp_d = m_bresp[{port_q, 1'b0} +: 2];
               state_d = BOUT;
            end
         end
         BOUT: if (s_bready) state_d = IDLE;
         RREQ: if (ar_hs) state_d = RRSP;
         RRSP: begin
            if (r_hit) begin
               rdata_d = m_rdata[{port_q, 5'b0} +: 32];
               rresp_d = m_rresp[{port_q, 1'b0} +: 2];
               state_d = ROUT;
            end
         end
         ROUT: if (s_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aruser_q  <= '0;
         port_q    <= '0;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aruser_q  <= aruser_d;
         port_q    <= port_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule
